// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, FSM states,
// and branch history counter geometry.
package ifetch_unit_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam int         CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_INIT = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_bht.sv
// Branch history table: 2-bit saturating counters with one combinational
// read port and one clocked update port.
module bht_predictor
    import ifetch_unit_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] upd_cur;

    assign upd_cur = cnt_q[upd_idx];

    // NOTE: every counter must start weakly not-taken, so the array is reset
    // entry by entry; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (rdy && upd_en) begin
            if (upd_taken && upd_cur != {CNT_W{1'b1}}) begin
                cnt_q[upd_idx] <= upd_cur + 1'b1;
            end else if (!upd_taken && upd_cur != '0) begin
                cnt_q[upd_idx] <= upd_cur - 1'b1;
            end
        end
    end

    // Read sees the pre-update value when it collides with a same-cycle write.
    assign rd_taken = cnt_q[rd_idx][CNT_W-1];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: one outstanding memory request, a one-word buffer, BHT/JAL
// next-PC prediction and ROB rollback with in-flight request kill.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BHT_IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        rs_nxt_full,
    input  logic        lsb_nxt_full,
    input  logic        rob_nxt_full,
    output logic        mc_en,
    output logic [31:0] mc_pc,
    input  logic        mc_done,
    input  logic [31:0] mc_data,
    output logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_pred_jump,
    input  logic        br_upd,
    input  logic [31:0] br_upd_pc,
    input  logic        br_upd_taken
);

    fetch_state_t state, state_d;
    logic [31:0] pc, pc_d, mc_pc_d, inst_d, inst_pc_d;
    logic [31:0] buf_word, buf_word_d, buf_pc, buf_pc_d, buf_target, buf_target_d;
    logic        kill, kill_d, mc_en_d, inst_rdy_d, inst_pred_jump_d;
    logic        buf_pred, buf_pred_d;

    logic        bht_taken, dec_pred, stall;
    logic [31:0] j_imm, b_imm, dec_target;
    logic        unused_upd_bits;

    assign unused_upd_bits = ^{br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[1:0], pc[31:BHT_IDX_W+2], pc[1:0]};

    bht_predictor #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_idx    (pc[BHT_IDX_W+1:2]),
        .rd_taken  (bht_taken),
        .upd_en    (br_upd),
        .upd_idx   (br_upd_pc[BHT_IDX_W+1:2]),
        .upd_taken (br_upd_taken)
    );

    // Prediction is formed from the word as it arrives, at the fetch PC.
    assign j_imm = {{11{mc_data[31]}}, mc_data[31], mc_data[19:12], mc_data[20], mc_data[30:21], 1'b0};
    assign b_imm = {{19{mc_data[31]}}, mc_data[31], mc_data[7], mc_data[30:25], mc_data[11:8], 1'b0};

    always_comb begin
        dec_pred   = 1'b0;
        dec_target = pc + 32'd4;
        case (mc_data[6:0])
            OPC_JAL: begin
                dec_pred   = 1'b1;
                dec_target = pc + j_imm;
            end
            OPC_BR: begin
                dec_pred   = bht_taken;
                dec_target = bht_taken ? pc + b_imm : pc + 32'd4;
            end
            OPC_JALR: dec_pred = 1'b0;
            default:  dec_pred = 1'b0;
        endcase
    end

    assign stall = rs_nxt_full | lsb_nxt_full | rob_nxt_full;

    // NOTE: every signal gets its hold value before the case split, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d          = state;
        pc_d             = pc;
        kill_d           = kill;
        mc_en_d          = mc_en;
        mc_pc_d          = mc_pc;
        inst_rdy_d       = 1'b0;
        inst_d           = inst;
        inst_pc_d        = inst_pc;
        inst_pred_jump_d = inst_pred_jump;
        buf_word_d       = buf_word;
        buf_pc_d         = buf_pc;
        buf_pred_d       = buf_pred;
        buf_target_d     = buf_target;

        if (rdy && rollback) begin
            pc_d = rollback_pc;
            if (state == S_WAIT && !mc_done) begin
                kill_d = 1'b1;
            end else begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
                mc_en_d = 1'b0;
            end
        end else if (rdy) begin
            case (state)
                S_IDLE: begin
                    mc_en_d = 1'b1;
                    mc_pc_d = pc;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mc_done) begin
                        mc_en_d = 1'b0;
                        if (kill) begin
                            kill_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            buf_word_d   = mc_data;
                            buf_pc_d     = pc;
                            buf_pred_d   = dec_pred;
                            buf_target_d = dec_target;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_rdy_d       = 1'b1;
                        inst_d           = buf_word;
                        inst_pc_d        = buf_pc;
                        inst_pred_jump_d = buf_pred;
                        pc_d             = buf_target;
                        state_d          = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            mc_en          <= 1'b0;
            mc_pc          <= '0;
            inst_rdy       <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            inst_pred_jump <= 1'b0;
            buf_word       <= '0;
            buf_pc         <= '0;
            buf_pred       <= 1'b0;
            buf_target     <= '0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            kill           <= kill_d;
            mc_en          <= mc_en_d;
            mc_pc          <= mc_pc_d;
            inst_rdy       <= inst_rdy_d;
            inst           <= inst_d;
            inst_pc        <= inst_pc_d;
            inst_pred_jump <= inst_pred_jump_d;
            buf_word       <= buf_word_d;
            buf_pc         <= buf_pc_d;
            buf_pred       <= buf_pred_d;
            buf_target     <= buf_target_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch handshake, prediction, stalls,
// rollback kill, freeze and mid-fetch reset.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic [31:0] rollback_pc;
    logic        rs_nxt_full, lsb_nxt_full, rob_nxt_full;
    logic        mc_en, mc_done;
    logic [31:0] mc_pc, mc_data;
    logic        inst_rdy, inst_pred_jump;
    logic [31:0] inst, inst_pc;
    logic        br_upd, br_upd_taken;
    logic [31:0] br_upd_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI    = 32'h0000_0013;
    localparam logic [31:0] JAL_P16 = 32'h0100_006F;
    localparam logic [31:0] JAL_P40 = 32'h0280_006F;
    localparam logic [31:0] JAL_M4  = 32'hFFDF_F06F;
    localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;
    localparam logic [31:0] BEQ_P8  = 32'h0000_0463;

    ifetch_unit #(.RESET_PC(32'h0), .BHT_IDX_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .rollback_pc    (rollback_pc),
        .rs_nxt_full    (rs_nxt_full),
        .lsb_nxt_full   (lsb_nxt_full),
        .rob_nxt_full   (rob_nxt_full),
        .mc_en          (mc_en),
        .mc_pc          (mc_pc),
        .mc_done        (mc_done),
        .mc_data        (mc_data),
        .inst_rdy       (inst_rdy),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pred_jump (inst_pred_jump),
        .br_upd         (br_upd),
        .br_upd_pc      (br_upd_pc),
        .br_upd_taken   (br_upd_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait for a fetch request, confirming its address and that no strobe slipped out.
    task automatic wait_req(input string tag, input logic [31:0] exp_pc);
        int  strobes = 0;
        bit  seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inst_rdy) strobes++;
            if (mc_en) seen = 1'b1;
        end
        check({tag, " req"}, 32'(seen), 32'd1);
        check({tag, " mc_pc"}, mc_pc, exp_pc);
        check({tag, " stray strobe"}, 32'(strobes), 32'd0);
    endtask

    task automatic do_done(input logic [31:0] word);
        mc_done = 1'b1;
        mc_data = word;
        @(negedge clk);
        mc_done = 1'b0;
        mc_data = 32'hDEAD_BEEF;
    endtask

    task automatic wait_strobe(input string tag, input logic [31:0] exp_inst,
                               input logic [31:0] exp_pc, input logic exp_pred);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inst_rdy) seen = 1'b1;
        end
        check({tag, " strobe"}, 32'(seen), 32'd1);
        check({tag, " inst"}, inst, exp_inst);
        check({tag, " inst_pc"}, inst_pc, exp_pc);
        check({tag, " pred"}, 32'(inst_pred_jump), 32'(exp_pred));
        @(negedge clk);
        check({tag, " single strobe"}, 32'(inst_rdy), 32'd0);
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc,
                         input logic [31:0] word, input logic pred);
        wait_req(tag, pc);
        do_done(word);
        wait_strobe(tag, word, pc, pred);
    endtask

    task automatic bht_update(input logic [31:0] pc, input logic taken);
        br_upd       = 1'b1;
        br_upd_pc    = pc;
        br_upd_taken = taken;
        @(negedge clk);
        br_upd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rollback_pc = '0;
        rs_nxt_full = 1'b0; lsb_nxt_full = 1'b0; rob_nxt_full = 1'b0;
        mc_done = 1'b0; mc_data = '0;
        br_upd = 1'b0; br_upd_pc = '0; br_upd_taken = 1'b0;

        repeat (3) @(negedge clk);
        check("rst mc_en", 32'(mc_en), 32'd0);
        check("rst mc_pc", mc_pc, 32'h0);
        check("rst inst_rdy", 32'(inst_rdy), 32'd0);
        check("rst inst", inst, 32'h0);
        check("rst inst_pc", inst_pc, 32'h0);
        check("rst pred", 32'(inst_pred_jump), 32'd0);
        rst = 1'b0;

        fetch("addi@0", 32'h0, ADDI, 1'b0);
        fetch("addi@4", 32'h4, ADDI, 1'b0);
        fetch("jal@8", 32'h8, JAL_P16, 1'b1);
        fetch("jal@18", 32'h18, JAL_P40, 1'b1);
        fetch("beq@40 cold", 32'h40, BEQ_P8, 1'b0);
        fetch("jal@44", 32'h44, JAL_M4, 1'b1);

        bht_update(32'h40, 1'b1);
        bht_update(32'h40, 1'b1);
        fetch("beq@40 strong", 32'h40, BEQ_P8, 1'b1);
        bht_update(32'h40, 1'b0);
        fetch("jal@48", 32'h48, JAL_M8, 1'b1);
        fetch("beq@40 weak", 32'h40, BEQ_P8, 1'b1);

        wait_req("stall", 32'h48);
        rob_nxt_full = 1'b1;
        do_done(ADDI);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall no strobe", 32'(inst_rdy), 32'd0);
        end
        rob_nxt_full = 1'b0;
        wait_strobe("stall", ADDI, 32'h48, 1'b0);

        wait_req("rb wait", 32'h4C);
        rollback = 1'b1; rollback_pc = 32'h100;
        @(negedge clk);
        rollback = 1'b0;
        check("rb kill mc_en", 32'(mc_en), 32'd1);
        @(negedge clk);
        do_done(ADDI);
        wait_req("rb target", 32'h100);

        rollback = 1'b1; rollback_pc = 32'h200;
        mc_done = 1'b1; mc_data = ADDI;
        @(negedge clk);
        rollback = 1'b0; mc_done = 1'b0;
        check("rb+done mc_en", 32'(mc_en), 32'd0);
        wait_req("rb+done target", 32'h200);

        rdy = 1'b0; rollback = 1'b1; rollback_pc = 32'h300;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("frz mc_en", 32'(mc_en), 32'd1);
            check("frz mc_pc", mc_pc, 32'h200);
            check("frz inst_rdy", 32'(inst_rdy), 32'd0);
        end
        rdy = 1'b1; rollback = 1'b0;
        do_done(ADDI);
        wait_strobe("after frz", ADDI, 32'h200, 1'b0);

        wait_req("pre rst", 32'h204);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst mc_en", 32'(mc_en), 32'd0);
        mc_done = 1'b1; mc_data = JAL_P16;
        @(negedge clk);
        mc_done = 1'b0;
        fetch("post rst", 32'h0, ADDI, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
